satd_mode_search: RTL and testbench
===================================

# satd_mode_search

Parametrised fractional-pel candidate evaluator for the FME stage. It computes the 4x4-Hadamard SATD of NUM_CAND reference candidates against the current block and accumulates the costs over 1, 2, 4 or 16 4x4 beats, selected by a runtime partition mode. It then scans the accumulated costs serially and reports the lowest-cost candidate index and its cost with a one-cycle done pulse. It sits between the half/quarter-pel interpolator and the FME mode decision, replacing the fixed nine-candidate, single-4x4 evaluator.

## Interface
- NUM_CAND, 9, number of candidates, must be at least 2
- PIX_W, 8, pixel width in bits, unsigned
- IDX_W, derived as $clog2(NUM_CAND), width of best_idx
- COST_W, derived as PIX_W+13, accumulator and cost width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a search; accepted only in IDLE
- mode  in  2  sampled with start. 0=4x4 (1 beat), 1=8x4/4x8 (2 beats), 2=8x8 (4 beats), 3=16x16 (16 beats)
- in_valid  in  1  a 4x4 beat is present on cur_pix/ref_pix
- in_ready  out  1  high while in ACCUM
- cur_pix  in  16*PIX_W  current 4x4 block; pixel k (raster order) is at [k*PIX_W +: PIX_W]
- ref_pix  in  NUM_CAND*16*PIX_W  candidate c, pixel k is at [(c*16+k)*PIX_W +: PIX_W]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse; result is valid
- best_idx  out  IDX_W  winning candidate
- best_cost  out  COST_W  winning accumulated raw SATD shifted right by 1

## Operation
- Reset: all FSM state goes to IDLE. in_ready, busy, done, best_idx, best_cost, accumulators, beat counter and stage-1 registers all reset to 0.
- FSM states: IDLE, ACCUM, DRAIN, SCAN, DONE.
- IDLE: when start=1, latch the beat count from mode, clear all NUM_CAND accumulators and the beat counter, then go to ACCUM.
- ACCUM: a beat is accepted on an edge where in_valid and in_ready are both high. Gaps in in_valid are allowed.
- Per-beat stage 1 (registered): for each candidate, D = cur - ref as a (PIX_W+1)-bit signed value, and T = H·D·Hᵀ with H rows [1,1,1,1], [1,1,-1,-1], [1,-1,-1,1], [1,-1,1,-1]. satd4 = Σ|T| over 16 coefficients. Width is PIX_W+9 unsigned, with no truncation.
- Stage 2: acc[c] += stage-1 satd4 when the stage-1 valid bit is set.
- When the last beat is accepted, go to DRAIN for 1 cycle so the final stage-1 value is added.
- SCAN: seed best = (0, acc[0]). On each cycle for idx = 1 … NUM_CAND-1, replace best only if acc[idx] < best (strict compare). Ties therefore keep the lower index. SCAN lasts NUM_CAND-1 cycles.
- DONE: done=1 for one cycle. best_idx is driven from best; best_cost is driven as best>>1. Both are held until the next search's DONE or reset. The next state is always IDLE.
- start is ignored outside IDLE, including during DONE.
- in_valid is ignored while in_ready=0.
- COST_W covers 16 beats of the maximal satd4 (16·16·(2^PIX_W−1)·… ≤ 2^(PIX_W+13)). No saturation is needed.

## Timing
- start is sampled at edge S. in_ready goes high after S.
- With back-to-back beats, the last beat is accepted at edge E = S+B, where B is the beat count.
- The state becomes DRAIN after E, SCAN after E+1, and DONE after E+NUM_CAND.
- done is high from edge E+NUM_CAND to edge E+NUM_CAND+1. For NUM_CAND=9 and mode 0, done is high 10 cycles after S.
- busy is high from S until the edge that leaves DONE.
- Reset asserted in any state immediately forces all outputs to 0. No partial result is ever emitted; the next search starts clean.

## Test plan
- Match, mode 0, NUM_CAND=9: cur all 100; ref[4] all 100; ref[c] all 100+|c−4|. Expect best_idx=4, best_cost=0, and done exactly 10 cycles after start.
- Tie, mode 0: cur all 50; ref[2] and ref[6] all 51 (raw 16 each); others all 60. Expect best_idx=2, best_cost=8.
- Mode 2 with gaps: 4 beats, with in_valid low for 2 cycles between beats. cur all 10. ref[5] equals cur except pixel 0 of beat 3 is 11. Every other candidate is all 11 on every beat. Expect best_idx=5, best_cost=8 (the others would be 32). done is timed from the last-beat edge.
- Width, mode 3: 16 beats, cur all 255, ref[c] all 0 except ref[8] all 1. Expect best_idx=8 and best_cost=(16·16·254)>>1=32512. Accumulators for c<8 reach 65280 without wrap.
- Reset mid-ACCUM: assert rst after 2 of 4 beats. All outputs go to 0 immediately. Then run a mode 0 search with ref[1]=cur. Expect best_idx=1, best_cost=0, with no residual from the aborted search.
- Protocol: a start pulse during SCAN and one during DONE are both ignored (single done pulse, busy drops). in_valid asserted during IDLE and SCAN does not change any result.

Source files
------------

// File: rtl/satd_mode_search.sv
// satd_mode_search: 4x4 Hadamard SATD over NUM_CAND fractional-pel candidates,
// accumulated over 1/2/4/16 beats per partition mode, then a serial min-scan.
module satd_mode_search #(
    parameter int unsigned NUM_CAND = 9,
    parameter int unsigned PIX_W    = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_CAND),
    localparam int unsigned COST_W  = PIX_W + 13
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [16*PIX_W-1:0]             cur_pix,
    input  logic [NUM_CAND*16*PIX_W-1:0]    ref_pix,
    output logic                            busy,
    output logic                            done,
    output logic [IDX_W-1:0]                best_idx,
    output logic [COST_W-1:0]               best_cost
);

    // Transform coefficient width (signed) and per-block SATD width (unsigned)
    localparam int unsigned T_W   = PIX_W + 5;
    localparam int unsigned S_W   = PIX_W + 9;
    localparam int unsigned BLK_W = 16 * PIX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t              state;
    logic [4:0]          beats_m1;
    logic [4:0]          beat_cnt;
    logic [S_W-1:0]      s1_satd [NUM_CAND];
    logic                s1_valid;
    logic [COST_W-1:0]   acc [NUM_CAND];
    logic [IDX_W-1:0]    scan_idx;
    logic [IDX_W-1:0]    run_idx;
    logic [COST_W-1:0]   run_cost;

    logic [S_W-1:0]      satd_c [NUM_CAND];
    logic                accept_c;
    logic [IDX_W-1:0]    base_idx_c;
    logic [COST_W-1:0]   base_cost_c;
    logic [IDX_W-1:0]    nxt_idx_c;
    logic [COST_W-1:0]   nxt_cost_c;

    // Sum of absolute 4x4 Hadamard coefficients of (a - b)
    function automatic logic [S_W-1:0] satd4(input logic [BLK_W-1:0] a,
                                             input logic [BLK_W-1:0] b);
        logic signed [T_W-1:0] d [16];
        logic signed [T_W-1:0] m [16];
        logic signed [T_W-1:0] t [16];
        logic signed [T_W-1:0] v;
        logic [S_W-1:0]        s;
        for (int k = 0; k < 16; k++) begin
            d[k] = $signed(T_W'(a[k*PIX_W +: PIX_W])) - $signed(T_W'(b[k*PIX_W +: PIX_W]));
        end
        // Column transform: M = H * D
        for (int j = 0; j < 4; j++) begin
            m[j]      = d[j] + d[4+j] + d[8+j] + d[12+j];
            m[4+j]    = d[j] + d[4+j] - d[8+j] - d[12+j];
            m[8+j]    = d[j] - d[4+j] - d[8+j] + d[12+j];
            m[12+j]   = d[j] - d[4+j] + d[8+j] - d[12+j];
        end
        // Row transform: T = M * H^T
        for (int i = 0; i < 4; i++) begin
            t[4*i]    = m[4*i] + m[4*i+1] + m[4*i+2] + m[4*i+3];
            t[4*i+1]  = m[4*i] + m[4*i+1] - m[4*i+2] - m[4*i+3];
            t[4*i+2]  = m[4*i] - m[4*i+1] - m[4*i+2] + m[4*i+3];
            t[4*i+3]  = m[4*i] - m[4*i+1] + m[4*i+2] - m[4*i+3];
        end
        s = '0;
        for (int k = 0; k < 16; k++) begin
            v = t[k];
            s = s + S_W'(v[T_W-1] ? -v : v);
        end
        return s;
    endfunction

    // Per-candidate SATD of the beat currently on the inputs
    always_comb begin
        for (int c = 0; c < NUM_CAND; c++) begin
            satd_c[c] = satd4(cur_pix, ref_pix[c*BLK_W +: BLK_W]);
        end
    end

    assign accept_c = in_valid & in_ready;

    // Scan step: compare the candidate at scan_idx against the running best
    always_comb begin
        base_idx_c  = run_idx;
        base_cost_c = run_cost;
        if (scan_idx == IDX_W'(1)) begin
            base_idx_c  = '0;
            base_cost_c = acc[0];
        end
        nxt_idx_c  = base_idx_c;
        nxt_cost_c = base_cost_c;
        if (acc[scan_idx] < base_cost_c) begin
            nxt_idx_c  = scan_idx;
            nxt_cost_c = acc[scan_idx];
        end
    end

    // Stage 1: register per-candidate SATD of each accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int c = 0; c < NUM_CAND; c++) s1_satd[c] <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                for (int c = 0; c < NUM_CAND; c++) s1_satd[c] <= satd_c[c];
            end
        end
    end

    // Stage 2: accumulators, cleared when a search is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CAND; c++) acc[c] <= '0;
        end else if (state == ST_IDLE && start) begin
            for (int c = 0; c < NUM_CAND; c++) acc[c] <= '0;
        end else if (s1_valid) begin
            for (int c = 0; c < NUM_CAND; c++) acc[c] <= acc[c] + COST_W'(s1_satd[c]);
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            beats_m1  <= '0;
            beat_cnt  <= '0;
            scan_idx  <= '0;
            run_idx   <= '0;
            run_cost  <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_idx  <= '0;
            best_cost <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (mode)
                            2'd0:    beats_m1 <= 5'd0;
                            2'd1:    beats_m1 <= 5'd1;
                            2'd2:    beats_m1 <= 5'd3;
                            default: beats_m1 <= 5'd15;
                        endcase
                        beat_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept_c) begin
                        beat_cnt <= beat_cnt + 5'd1;
                        if (beat_cnt == beats_m1) begin
                            in_ready <= 1'b0;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    scan_idx <= IDX_W'(1);
                    state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    run_idx  <= nxt_idx_c;
                    run_cost <= nxt_cost_c;
                    scan_idx <= scan_idx + IDX_W'(1);
                    if (scan_idx == IDX_W'(NUM_CAND - 1)) begin
                        best_idx  <= nxt_idx_c;
                        best_cost <= COST_W'(nxt_cost_c >> 1);
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_satd_mode_search.sv
// Directed bench for satd_mode_search with hand-computed costs and latencies.
module tb_satd_mode_search;

    localparam int unsigned NC    = 9;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned IDX_W = $clog2(NC);
    localparam int unsigned COST_W = PIX_W + 13;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [1:0]                 mode;
    logic                       in_valid;
    logic                       in_ready;
    logic [16*PIX_W-1:0]        cur_pix;
    logic [NC*16*PIX_W-1:0]     ref_pix;
    logic                       busy;
    logic                       done;
    logic [IDX_W-1:0]           best_idx;
    logic [COST_W-1:0]          best_cost;

    logic [PIX_W-1:0]           cur_a [16];
    logic [PIX_W-1:0]           ref_a [NC][16];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    satd_mode_search #(.NUM_CAND(NC), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cur_pix   (cur_pix),
        .ref_pix   (ref_pix),
        .busy      (busy),
        .done      (done),
        .best_idx  (best_idx),
        .best_cost (best_cost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            cur_pix[k*PIX_W +: PIX_W] = cur_a[k];
            for (int c = 0; c < NC; c++) ref_pix[(c*16+k)*PIX_W +: PIX_W] = ref_a[c][k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Load pixel data of beat b for scenario tid
    task automatic build_beat(input int tid, input int b);
        for (int k = 0; k < 16; k++) begin
            case (tid)
                1: begin
                    cur_a[k] = 8'd100;
                    for (int c = 0; c < NC; c++) ref_a[c][k] = PIX_W'(100 + ((c > 4) ? c - 4 : 4 - c));
                end
                2: begin
                    cur_a[k] = 8'd50;
                    for (int c = 0; c < NC; c++) ref_a[c][k] = (c == 2 || c == 6) ? 8'd51 : 8'd60;
                end
                3: begin
                    cur_a[k] = 8'd10;
                    for (int c = 0; c < NC; c++) ref_a[c][k] = 8'd11;
                    ref_a[5][k] = (b == 3 && k == 0) ? 8'd11 : 8'd10;
                end
                4: begin
                    cur_a[k] = 8'd255;
                    for (int c = 0; c < NC; c++) ref_a[c][k] = 8'd0;
                    ref_a[8][k] = 8'd1;
                end
                5: begin
                    cur_a[k] = 8'd77;
                    for (int c = 0; c < NC; c++) ref_a[c][k] = PIX_W'(80 + c);
                    ref_a[1][k] = 8'd77;
                end
                default: begin
                    // Garbage: every candidate equal to cur, would make idx 0 win at cost 0
                    cur_a[k] = 8'd33;
                    for (int c = 0; c < NC; c++) ref_a[c][k] = 8'd33;
                end
            endcase
        end
    endtask

    // Run one search; returns cycles from start edge and from last-beat edge to done
    task automatic run_search(input int tid, input logic [1:0] m, input int nb, input int gap,
                              input bit noisy, output int lat_s, output int lat_e, output bit seen);
        int s_c;
        int e_c;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_c = cyc;
        for (int b = 0; b < nb; b++) begin
            build_beat(tid, b);
            in_valid = 1'b1;
            @(negedge clk);
            if (gap > 0 && b < nb - 1) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        e_c = cyc;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (noisy) begin
                build_beat(0, 0);
                in_valid = 1'b1;
                start = (i == 3);
            end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        lat_s = cyc - s_c;
        lat_e = cyc - e_c;
    endtask

    // Result checks common to every completed search
    task automatic check_result(input string tag, input int exp_idx, input int exp_cost,
                                input int lat_e, input bit seen);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_idx"}, 32'(best_idx), 32'(exp_idx));
        check({tag, "_cost"}, 32'(best_cost), 32'(exp_cost));
        check({tag, "_lat_last_beat"}, 32'(lat_e), 32'd9);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_idx_hold"}, 32'(best_idx), 32'(exp_idx));
    endtask

    initial begin
        int  ls;
        int  le;
        bit  sn;
        int  stray;
        rst = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        in_valid = 1'b0;
        build_beat(0, 0);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(best_idx), 32'd0);
        check("rst_cost", 32'(best_cost), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Exact match at candidate 4
        run_search(1, 2'd0, 1, 0, 1'b0, ls, le, sn);
        check("match_lat_start", 32'(ls), 32'd10);
        check_result("match", 4, 0, le, sn);

        // Tie between candidates 2 and 6 keeps the lower index
        run_search(2, 2'd0, 1, 0, 1'b0, ls, le, sn);
        check_result("tie", 2, 8, le, sn);

        // 8x8 with two idle cycles between beats
        run_search(3, 2'd2, 4, 2, 1'b0, ls, le, sn);
        check_result("gaps", 5, 8, le, sn);

        // 16x16 at full pixel swing
        run_search(4, 2'd3, 16, 0, 1'b0, ls, le, sn);
        check("wide_lat_start", 32'(ls), 32'd25);
        check_result("wide", 8, 32512, le, sn);

        // Abort after two of four beats
        @(negedge clk);
        mode = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        build_beat(4, 0);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_idx", 32'(best_idx), 32'd0);
        check("abort_cost", 32'(best_cost), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_search(5, 2'd0, 1, 0, 1'b0, ls, le, sn);
        check_result("post_rst", 1, 0, le, sn);

        // Stray in_valid in IDLE, start and in_valid during SCAN, start during DONE
        build_beat(0, 0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        run_search(1, 2'd0, 1, 0, 1'b1, ls, le, sn);
        check("proto_done_seen", 32'(sn), 32'd1);
        check("proto_idx", 32'(best_idx), 32'd4);
        check("proto_cost", 32'(best_cost), 32'd0);
        start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        check("proto_done_pulse", 32'(done), 32'd0);
        check("proto_busy_drop", 32'(busy), 32'd0);
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy || in_ready) stray++;
        end
        check("proto_no_restart", 32'(stray), 32'd0);
        check("proto_idx_hold", 32'(best_idx), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
